// File: rtl/debounce_pio.sv
// debounce_pio: debounced button/switch PIO with edge capture and interrupt.
//
// Each in_port bit is synchronised (2 flops), then debounced by a per-bit
// counter: a new level must be seen on DEBOUNCE_CYCLES consecutive edges
// before it replaces the debounced value. Qualified transitions of the
// selected polarity set a sticky edgecap bit; irq = |(edgecap & irqmask).
//
// Ports:
//   clk, reset_n       clock, async active-low reset
//   address[1:0]       0 = stable (RO), 1 = reserved (reads 0),
//                      2 = irqmask (RW), 3 = edgecap (R, write-1-to-clear)
//   chipselect,write_n write strobe (write when chipselect & !write_n)
//   writedata[WIDTH]   write data
//   in_port[WIDTH]     raw asynchronous inputs
//   readdata[WIDTH]    registered read data, one-cycle latency, unqualified
//   irq                level interrupt, active high

// Per-bit synchroniser + debouncer. o_edge pulses on the same edge that
// r_stable takes its new value, filtered by EDGE_MODE polarity.
module debounce_pio_lane #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 0,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_in,
  output logic o_stable,
  output logic o_edge
);
  logic          r_sync1, r_sync2, r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_diff, w_done;

  assign w_diff = r_sync2 ^ r_stable;
  assign w_done = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;                 // agreement (or glitch ended) restarts qualification
      end else if (w_done) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;
  // r_sync2 is the level being adopted, so it gives the direction of the change
  assign o_edge = (EDGE_MODE == 0) ? (w_done &  r_sync2) :
                  (EDGE_MODE == 1) ? (w_done & ~r_sync2) :
                                      w_done;
endmodule

module debounce_pio #(
  parameter int WIDTH           = 12,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] readdata,
  output logic             irq
);
  logic [WIDTH-1:0] w_stable, w_edge, w_clr;
  logic [WIDTH-1:0] r_edgecap, r_irqmask, r_readdata;
  logic             w_wr;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      debounce_pio_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .EDGE_MODE      (EDGE_MODE)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .i_in    (in_port[gi]),
        .o_stable(w_stable[gi]),
        .o_edge  (w_edge[gi])
      );
    end
  endgenerate

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && address == 2'd3) ? writedata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask  <= '0;
      r_edgecap  <= '0;
      r_readdata <= '0;
    end else begin
      if (w_wr && address == 2'd2) r_irqmask <= writedata;
      // set is OR'd in after the clear so a coincident capture survives
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      case (address)
        2'd0:    r_readdata <= w_stable;
        2'd2:    r_readdata <= r_irqmask;
        2'd3:    r_readdata <= r_edgecap;
        default: r_readdata <= '0;
      endcase
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edgecap & r_irqmask);
endmodule
